// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  // Scan sequencer states: dark, driving a digit, inter-digit dead time
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // Hex font, segment order {a,b,c,d,e,f,g}, active-high; index is the nibble
  localparam logic [6:0] HEX_FONT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to seven-segment glyph lookup.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Straight table lookup into the shared font
  always_comb begin
    seg = HEX_FONT[nib];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed NDIG-digit seven-segment scanner with frame-aligned double buffer.
// Latency: seg/an/frame_done registered, one cycle after their cause; updates show within one frame + 1.
// Backpressure: upd_ready drops while an accepted update waits for the next frame boundary.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 1000,
  parameter int GAP_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              blank_lz,
  input  logic              upd_valid,
  input  logic [4*NDIG-1:0] upd_data,
  output logic              upd_ready,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(NDIG);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(TICK_DIV - GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] DIG_LAST  = IDX_W'(NDIG - 1);

  scan_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic [4*NDIG-1:0] disp_buf;
  logic [4*NDIG-1:0] pend_buf;
  logic              pend_vld;

  logic [3:0]        cur_nib;
  logic [6:0]        font_seg;
  logic [NDIG-1:0]   zero_from;   // bit k: nibbles k..NDIG-1 of disp_buf are all zero
  logic [NDIG-1:0]   cur_onehot;
  logic              cur_blank;
  logic              xfer;
  logic              frame_end;
  logic              swap;

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (font_seg)
  );

  // Select the active digit's nibble and work out leading-zero blanking
  always_comb begin
    cur_nib    = disp_buf[{dig_idx, 2'b00} +: 4];
    cur_onehot = {{(NDIG-1){1'b0}}, 1'b1} << dig_idx;
    zero_from  = '0;
    for (int k = 0; k < NDIG; k++) begin
      zero_from[k] = ((disp_buf >> (4 * k)) == '0);
    end
    cur_blank = blank_lz && (dig_idx != '0) && zero_from[dig_idx];
  end

  // Handshake and swap qualifiers; swaps happen on the last gap cycle of the
  // last digit, or straight away while the display is off
  always_comb begin
    xfer      = upd_valid && upd_ready;
    frame_end = en && (state == GAP) && (cnt == SLOT_LAST) && (dig_idx == DIG_LAST);
    swap      = pend_vld && (frame_end || (state == OFF));
  end

  // Double buffer: capture offered values, promote them at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_buf  <= '0;
      pend_vld  <= 1'b0;
      disp_buf  <= '0;
      upd_ready <= 1'b1;
    end else begin
      if (xfer) begin
        pend_buf  <= upd_data;
        pend_vld  <= 1'b1;
        upd_ready <= 1'b0;
      end else if (swap) begin
        disp_buf  <= pend_buf;
        pend_vld  <= 1'b0;
        upd_ready <= 1'b1;
      end
    end
  end

  // Scan sequencer with registered digit, segment and frame outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      cnt        <= '0;
      dig_idx    <= '0;
      an         <= '0;
      seg        <= '0;
      frame_done <= 1'b0;
    end else begin
      an         <= '0;
      seg        <= '0;
      frame_done <= 1'b0;
      if (!en) begin
        state   <= OFF;
        cnt     <= '0;
        dig_idx <= '0;
      end else begin
        case (state)
          OFF: begin
            state   <= SHOW;
            cnt     <= '0;
            dig_idx <= '0;
          end
          SHOW: begin
            an  <= cur_onehot;
            seg <= cur_blank ? 7'b0 : font_seg;
            cnt <= cnt + 1'b1;
            if (cnt == SHOW_LAST) state <= GAP;
          end
          GAP: begin
            if (cnt == SLOT_LAST) begin
              cnt        <= '0;
              state      <= SHOW;
              dig_idx    <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
              frame_done <= frame_end;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= OFF;
        endcase
      end
    end
  end

endmodule
